// File: rtl/alu_pkg.sv
// Shared opcode definitions for the ALU and its issue front end.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_LAST = 3'b100;

    // Opcodes above OP_LAST are reserved and produce an error entry.
    function automatic logic op_is_legal(input logic [2:0] op);
        return (op <= OP_LAST);
    endfunction

endpackage

// File: rtl/Optimized_ALU.sv
// Combinational ALU: add/sub with signed overflow, plus bitwise ops.
module Optimized_ALU #(
    parameter int N = 32
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   OP,
    output logic [N-1:0] C,
    output logic         OV
);

    // Select the operation; overflow is only meaningful for add/sub.
    always_comb begin
        // NOTE: default every output first so no path leaves it unassigned (no latch).
        C  = '0;
        OV = 1'b0;
        case (OP)
            3'b000: begin
                C  = A + B;
                OV = (A[N-1] == B[N-1]) && (C[N-1] != A[N-1]);
            end
            3'b001: begin
                C  = A - B;
                OV = (A[N-1] != B[N-1]) && (C[N-1] != A[N-1]);
            end
            3'b010:  C = A & B;
            3'b011:  C = A | B;
            3'b100:  C = A ^ B;
            default: C = '0;
        endcase
    end

endmodule

// File: rtl/alu_result_fifo.sv
// In-order circular result buffer with an explicit occupancy count.
module alu_result_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Head entry, forced to zero while the buffer is empty.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally; the count alone distinguishes full from empty.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents are only observed through a valid head.
    always_ff @(posedge clk) begin
        // NOTE: the array is not reset; the empty flag masks stale entries.
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Registered valid/ready front end around Optimized_ALU with a result FIFO.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [2:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_c,
    output logic         out_ov,
    output logic         out_err,
    output logic [15:0]  ov_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = N + 2;

    logic          s1_valid;
    logic [N-1:0]  s1_a;
    logic [N-1:0]  s1_b;
    logic [2:0]    s1_op;

    logic [N-1:0]  alu_c;
    logic          alu_ov;

    logic          accept;
    logic          push;
    logic          pop;
    logic          s1_legal;
    logic [EW-1:0] push_data;
    logic [EW-1:0] head_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] occupancy;

    // Reserve a FIFO slot for the entry sitting in S1 so it can always push.
    assign occupancy = fifo_count + CW'(s1_valid);
    assign in_ready  = (occupancy < CW'(DEPTH));
    assign accept    = in_valid && in_ready;

    assign s1_legal  = op_is_legal(s1_op);
    assign push      = s1_valid && !fifo_full;
    assign pop       = out_valid && out_ready;
    assign push_data = s1_legal ? {alu_c, alu_ov, 1'b0} : {{N{1'b0}}, 1'b0, 1'b1};

    assign out_valid = !fifo_empty;
    assign {out_c, out_ov, out_err} = head_data;

    // Stage S1 captures accepted requests and empties when it pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= in_op;
        end else if (push) begin
            s1_valid <= 1'b0;
        end
    end

    // Saturating count of legal results pushed with overflow set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ov_count <= '0;
        end else if (push && s1_legal && alu_ov && (ov_count != 16'hFFFF)) begin
            ov_count <= ov_count + 16'd1;
        end
    end

    Optimized_ALU #(.N(N)) u_alu (
        .A  (s1_a),
        .B  (s1_b),
        .OP (s1_op),
        .C  (alu_c),
        .OV (alu_ov)
    );

    alu_result_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit.
module tb_alu_issue_unit;

    localparam int N     = 32;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic [2:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_c;
    logic         out_ov;
    logic         out_err;
    logic [15:0]  ov_count;

    int           checks = 0;
    int           errors = 0;
    int           acc_count = 0;
    int           cycle = 0;
    logic [N+1:0] sb[$];
    int           pop_cyc[$];

    alu_issue_unit #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c     (out_c),
        .out_ov    (out_ov),
        .out_err   (out_err),
        .ov_count  (ov_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: {c, ov, err}.
    function automatic logic [N+1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] op);
        logic [N-1:0] c;
        logic         ov;
        ov = 1'b0;
        case (op)
            3'b000: begin c = a + b; ov = (a[N-1] == b[N-1]) && (c[N-1] != a[N-1]); end
            3'b001: begin c = a - b; ov = (a[N-1] != b[N-1]) && (c[N-1] != a[N-1]); end
            3'b010: c = a & b;
            3'b011: c = a | b;
            3'b100: c = a ^ b;
            default: return {{N{1'b0}}, 1'b0, 1'b1};
        endcase
        return {c, ov, 1'b0};
    endfunction

    // Monitor: compare popped heads, then record newly accepted requests.
    always @(negedge clk) begin
        logic [N+1:0] e;
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("result", 64'({out_c, out_ov, out_err}), 64'(e));
                    pop_cyc.push_back(cycle);
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_a, in_b, in_op));
                acc_count++;
            end
        end
    end

    // Present one request from posedge+1 until accepted (bounded).
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] op);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int t = 0; t < 200; t++) begin
            if (sb.size() == 0 && !out_valid) break;
            @(posedge clk);
            #1;
        end
        check("drain", 64'(sb.size() == 0 && !out_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int base;
        int t0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_c", 64'(out_c), 64'd0);
        check("rst_out_ov", 64'(out_ov), 64'd0);
        check("rst_out_err", 64'(out_err), 64'd0);
        check("rst_ov_count", 64'(ov_count), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single add with latency check.
        out_ready = 1'b1;
        send(32'd345, 32'd234, 3'b000);
        check("add_valid_e0", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("add_valid_e1", 64'(out_valid), 64'd1);
        check("add_c", 64'(out_c), 64'd579);
        drain();

        // Back-pressure: exactly DEPTH accepts with out_ready low.
        out_ready = 1'b0;
        base = acc_count;
        for (int i = 1; i <= 4; i++) send(32'(i), 32'd1, 3'b000);
        in_valid = 1'b1;
        in_a     = 32'd5;
        in_b     = 32'd1;
        in_op    = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        check("bp_accepts", 64'(acc_count - base), 64'd4);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_head", 64'(out_c), 64'd2);
        out_ready = 1'b1;
        send(32'd5, 32'd1, 3'b000);
        send(32'd6, 32'd1, 3'b000);
        check("bp_accepts_all", 64'(acc_count - base), 64'd6);
        drain();

        // Signed overflow.
        send(32'h7FFF_FFFF, 32'd1, 3'b000);
        @(posedge clk);
        #1;
        check("ovf_c", 64'(out_c), 64'h8000_0000);
        check("ovf_ov", 64'(out_ov), 64'd1);
        drain();
        check("ovf_count", 64'(ov_count), 64'd1);

        // Illegal opcode.
        send(32'd67, 32'd24, 3'b110);
        @(posedge clk);
        #1;
        check("ill_err", 64'(out_err), 64'd1);
        check("ill_c", 64'(out_c), 64'd0);
        drain();
        check("ill_ov_count", 64'(ov_count), 64'd1);

        // Streaming subtracts with simultaneous push/pop.
        pop_cyc.delete();
        t0 = cycle;
        for (int i = 0; i < 10; i++) send(32'd672, 32'd85, 3'b001);
        check("stream_accept_cycles", 64'(cycle - t0), 64'd10);
        drain();
        check("stream_pops", 64'(pop_cyc.size()), 64'd10);
        for (int k = 1; k < pop_cyc.size(); k++)
            check("stream_gap", 64'(pop_cyc[k] - pop_cyc[k-1]), 64'd1);

        // Reset mid-stream with queued results and a request held during reset.
        out_ready = 1'b0;
        send(32'd1, 32'd2, 3'b000);
        send(32'd3, 32'd4, 3'b000);
        send(32'd5, 32'd6, 3'b000);
        @(posedge clk);
        #1;
        check("mid_queued", 64'(out_valid), 64'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_a     = 32'd9;
        in_b     = 32'd9;
        in_op    = 3'b000;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_c", 64'(out_c), 64'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_in_ready", 64'(in_ready), 64'd1);
        check("mid_ov_count", 64'(ov_count), 64'd0);
        check("mid_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(32'd10, 32'd20, 3'b000);
        @(posedge clk);
        #1;
        check("post_rst_c", 64'(out_c), 64'd30);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("final_empty", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential front end for the combinational `Optimized_ALU`. It accepts operations over a valid/ready request port and registers the operands. It then drives the ALU from that register and queues each result, with its overflow flag, in a small in-order FIFO that feeds a valid/ready response port. It sits between the CPU's decode/issue logic and writeback, and gives the purely combinational ALU a registered, back-pressurable interface.

## Interface
- `N`, 32, operand/result width (passed to `Optimized_ALU`)
- `DEPTH`, 4, result FIFO entries (power of two, ≥2)
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `in_valid` in 1: request valid
- `in_ready` out 1: unit can accept a request this cycle
- `in_a` in N: operand A
- `in_b` in N: operand B
- `in_op` in 3: ALU opcode
- `out_valid` out 1: FIFO head holds a result
- `out_ready` in 1: consumer takes the head this cycle
- `out_c` out N: result
- `out_ov` out 1: ALU overflow flag for this result
- `out_err` out 1: opcode was illegal (3'b101–3'b111)
- `ov_count` out 16: number of results queued with `out_ov`=1, saturating

## Operation
- Request handshake: a request is accepted on a rising edge with `in_valid && in_ready`. `in_*` are captured into stage register S1 and `s1_valid` is set.
- `in_ready = (fifo_count + s1_valid) < DEPTH`. It comes from registered state only and has no combinational path from `in_valid` or `out_ready`.
- ALU operation:
  - S1 drives `Optimized_ALU` A/B/OP directly.
  - For legal opcodes 3'b000–3'b100, the ALU outputs C/OV are pushed into the FIFO on the next edge.
- Illegal opcode (3'b101–3'b111):
  - The ALU output is ignored.
  - The pushed entry is {C=0, OV=0, err=1}.
  - `ov_count` is not incremented.
- `s1_valid` clears on the push edge unless a new request is accepted on the same edge.
- FIFO:
  - Circular buffer with `DEPTH` entries, width N+2.
  - `out_*` are taken from the head entry.
  - Pop occurs on `out_valid && out_ready`.
  - Push and pop on the same edge are allowed; the count is then unchanged.
- Wrap-around: read and write pointers are log2(DEPTH) bits and wrap naturally. Full and empty are tracked by a separate count (0..DEPTH).
- `ov_count` increments on each push with OV=1 and holds at 16'hFFFF.
- `out_c`/`out_ov`/`out_err` are don't-care while `out_valid`=0. The implementation drives 0 in that case.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_c`=0, `out_ov`=0, `out_err`=0, `ov_count`=0.
  - `s1_valid`=0, pointers=0, count=0.
- Latency: a request accepted at edge E0 is pushed at E1. `out_valid` is high after E1 if the FIFO was empty.
- Throughput: one result per cycle while `out_ready`=1.
- Results leave in acceptance order; none is dropped or duplicated.
- Back-pressure with `out_ready`=0: exactly `DEPTH` requests are accepted, then `in_ready`=0.
- Reset asserted mid-operation:
  - All outputs immediately take their reset values.
  - In-flight S1 and FIFO contents are discarded.
  - Requests presented during reset are not accepted.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `OP_ADD`=3'b000, `OP_SUB`=3'b001, `OP_LAST`=3'b100.
  - Function `op_is_legal`.
- Sub-module `alu_result_fifo`: parameters WIDTH and DEPTH, push/pop/full/empty/count.
- Existing `Optimized_ALU #(.N(N))` is instantiated unchanged.
- Target size: about 200 RTL lines in total.

## Test plan
- Single add: A=345, B=234, OP=000, `out_ready`=1. Expect `out_c`=579, `out_ov`=0, `out_err`=0, with `out_valid` asserted one edge after the accept edge.
- Back-pressure:
  - Stimulus: `out_ready`=0, and 6 consecutive requests with A=1..6, B=1, OP=000.
  - Expect `in_ready` to fall after exactly 4 accepts.
  - Then raise `out_ready`. Expect results 2,3,4,5 in order, `in_ready` to return, and the remaining 2 requests to be accepted.
- Overflow: A=32'h7FFFFFFF, B=1, OP=000. Expect `out_c`=32'h80000000, `out_ov`=1, `ov_count`=1.
- Illegal opcode: A=67, B=24, OP=3'b110. Expect `out_c`=0, `out_ov`=0, `out_err`=1, `ov_count` unchanged.
- Streaming with simultaneous push/pop:
  - Stimulus: 10 back-to-back subtracts (A=672, B=85), `out_ready`=1 throughout.
  - Expect 10 results of 587 on 10 consecutive cycles and `in_ready` never low.
- Reset mid-stream: queue 3 results with `out_ready`=0, then assert `rst` for one cycle. Expect `out_valid`=0 immediately, `in_ready`=1 and `ov_count`=0 after release, and no stale result on the next request.
